// File: rtl/instr_prefetch_pkg.sv
// Shared types and widths for the instruction prefetch front end.
// Used by instr_prefetch and its skid FIFO (fetch_skid_fifo).
package instr_prefetch_pkg;

    localparam int RISCV_ADDR_WIDTH = 32;
    localparam int RISCV_WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } prefetch_state_e;

    typedef struct packed {
        logic [RISCV_WORD_WIDTH-1:0] instr;
        logic [RISCV_ADDR_WIDTH-1:0] addr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_skid_fifo.sv
// fetch_skid_fifo: small FIFO of {instr, addr} entries that absorbs fetch
// responses while the realign buffer is full; flush empties it in one cycle.
module fetch_skid_fifo
    import instr_prefetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  fetch_entry_t     data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output fetch_entry_t     data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]    LAST    = PW'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push_i && !flush_i;
    assign w_do_pop  = pop_i && !flush_i && (r_count != '0);

    assign data_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;
    assign empty_o = (r_count == '0);
    assign full_o  = (r_count == DEPTH_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= data_i;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(w_do_push && full_o));

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch: issues word fetches, tracks credit, drops stale
// responses after redirects. Optional perf counters: PREFETCH_PERF_CNT_EN.
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR       = 32'h0000_0080,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          FIFO_DEPTH      = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        fetch_enable_i,
    input  logic                        branch_i,
    input  logic [RISCV_ADDR_WIDTH-1:0] branch_target_i,
    output logic                        instr_req_o,
    output logic [RISCV_ADDR_WIDTH-1:0] instr_addr_o,
    input  logic                        instr_gnt_i,
    input  logic                        instr_rvalid_i,
    input  logic [RISCV_WORD_WIDTH-1:0] instr_rdata_i,
    output logic                        buf_write_en_o,
    output logic [RISCV_WORD_WIDTH-1:0] buf_instr_o,
    output logic [RISCV_ADDR_WIDTH-1:0] buf_addr_o,
    output logic                        buf_clear_o,
    output logic                        buf_read_offset_o,
    input  logic                        buf_full_i
`ifdef PREFETCH_PERF_CNT_EN
    ,
    output logic [31:0]                 perf_discard_cnt_o,
    output logic [31:0]                 perf_stall_cnt_o
`endif
);

    localparam int CW    = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);
    localparam int AQ_PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0]    MAX_OUT_C = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0]    DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [AQ_PW-1:0] AQ_LAST   = AQ_PW'(MAX_OUTSTANDING - 1);

    prefetch_state_e             r_state;
    logic [29:0]                 r_pc;
    logic                        r_redirect;
    logic [29:0]                 r_redirect_pc;
    logic [CW-1:0]               r_outstanding;
    logic [CW-1:0]               r_discard;
    logic [RISCV_ADDR_WIDTH-1:0] r_aq [MAX_OUTSTANDING];
    logic [AQ_PW-1:0]            r_aq_wr;
    logic [AQ_PW-1:0]            r_aq_rd;

    logic          w_gnt;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_credit;
    logic          w_fifo_empty;
    logic          w_fifo_full;
    logic [CW-1:0] w_fifo_count;
    logic [CW-1:0] w_fifo_next;
    logic [CW-1:0] w_out_next;
    logic [CW-1:0] w_discard_next;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head;
    logic          w_unused_target_lsb;

    assign w_unused_target_lsb = branch_target_i[0];

    assign instr_addr_o      = {r_pc, 2'b00};
    assign buf_clear_o       = branch_i;
    assign buf_read_offset_o = branch_i & branch_target_i[1];

    assign w_gnt  = instr_req_o && instr_gnt_i;
    // Responses arriving in a redirect cycle belong to the old stream too.
    assign w_drop = instr_rvalid_i && (branch_i || (r_discard != '0));
    assign w_push = instr_rvalid_i && !w_drop;
    assign w_pop  = !w_fifo_empty && !buf_full_i && !branch_i;

    assign buf_write_en_o = w_pop;
    assign buf_instr_o    = w_head.instr;
    assign buf_addr_o     = w_head.addr;

    assign w_push_entry.instr = instr_rdata_i;
    assign w_push_entry.addr  = r_aq[r_aq_rd];

    assign w_out_next  = r_outstanding + CW'(w_gnt) - CW'(instr_rvalid_i);
    assign w_fifo_next = branch_i ? '0 : (w_fifo_count + CW'(w_push) - CW'(w_pop));
    // Every in-flight word keeps a FIFO slot reserved, so pushes never overflow.
    assign w_credit    = (w_out_next < MAX_OUT_C) && ((w_out_next + w_fifo_next) < DEPTH_C);

    assign w_discard_next = branch_i ? w_out_next
                          : (r_discard + CW'(w_gnt && r_redirect)
                                       - CW'(instr_rvalid_i && (r_discard != '0)));

    fetch_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CW)
    ) u_skid_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .data_i  (w_push_entry),
        .pop_i   (w_pop),
        .flush_i (branch_i),
        .data_o  (w_head),
        .count_o (w_fifo_count),
        .empty_o (w_fifo_empty),
        .full_o  (w_fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            instr_req_o   <= 1'b0;
            r_pc          <= BOOT_ADDR[31:2];
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            case (r_state)
                IDLE, HOLD: begin
                    if (fetch_enable_i && w_credit) begin
                        r_state     <= REQ;
                        instr_req_o <= 1'b1;
                    end else if (!fetch_enable_i) begin
                        r_state <= IDLE;
                    end
                end
                REQ: begin
                    if (instr_gnt_i && !(fetch_enable_i && w_credit)) begin
                        r_state     <= fetch_enable_i ? HOLD : IDLE;
                        instr_req_o <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    instr_req_o <= 1'b0;
                end
            endcase

            // An ungranted request must complete at its old address; park the target.
            if (branch_i) begin
                if (instr_req_o && !instr_gnt_i) begin
                    r_redirect    <= 1'b1;
                    r_redirect_pc <= branch_target_i[31:2];
                end else begin
                    r_redirect <= 1'b0;
                    r_pc       <= branch_target_i[31:2];
                end
            end else if (w_gnt) begin
                r_redirect <= 1'b0;
                r_pc       <= r_redirect ? r_redirect_pc : r_pc + 30'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
            r_discard     <= '0;
            r_aq_wr       <= '0;
            r_aq_rd       <= '0;
        end else begin
            r_outstanding <= w_out_next;
            r_discard     <= w_discard_next;
            if (w_gnt)          r_aq_wr <= (r_aq_wr == AQ_LAST) ? '0 : r_aq_wr + 1'b1;
            if (instr_rvalid_i) r_aq_rd <= (r_aq_rd == AQ_LAST) ? '0 : r_aq_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_gnt) r_aq[r_aq_wr] <= instr_addr_o;
    end

`ifdef PREFETCH_PERF_CNT_EN
    logic [31:0] r_perf_discard;
    logic [31:0] r_perf_stall;

    assign perf_discard_cnt_o = r_perf_discard;
    assign perf_stall_cnt_o   = r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_discard <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_drop && (r_perf_discard != '1))
                r_perf_discard <= r_perf_discard + 32'd1;
            if (!w_fifo_empty && buf_full_i && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end
`endif

endmodule
